// File: rtl/fetch_unit_pkg.sv
// Fetch unit shared types and constants.
// Optional event counters are enabled with FETCH_STATS_EN.
package fetch_unit_pkg;

  localparam int INST_WIDTH = 32;
  localparam int ADDR_WIDTH = 64;
  localparam int PC_STEP    = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FLUSH = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [INST_WIDTH-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer holding {pc, inst} entries.
// Flush empties the buffer and wins over push and pop.
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t push_data,
  output fetch_entry_t head,
  output logic         empty,
  output logic [CW-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush &&
                   ((count < FULL) || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  // store the pushed entry at the tail
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // advance pointers and track occupancy
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (do_pop && !do_push) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues sequential requests, buffers replies.
// Define FETCH_STATS_EN to add stat_fetched/stat_flushes counters.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [63:0] inst_pc
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] stat_fetched,
  output logic [31:0] stat_flushes
`endif
);

  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int SW = CW + 1;

  fetch_state_e         state;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] target;
  logic [ADDR_WIDTH-1:0] rsp_pc;
  logic [CW-1:0]        outstanding;
  logic [CW-1:0]        out_next;
  logic [CW-1:0]        occupancy;
  logic                 in_fetch;
  logic                 req_fire;
  logic                 rsp_take;
  logic                 push;
  logic                 pop;
  logic                 flush;
  logic                 buf_empty;
  fetch_entry_t         rsp_entry;
  fetch_entry_t         head;

  assign in_fetch  = (state == FETCH);
  assign target    = redirect_pc & ~64'h3;
  assign imem_addr = pc;

  assign imem_req_valid = in_fetch &&
    ((SW'(outstanding) + SW'(occupancy)) <
     SW'(BUF_DEPTH));

  assign req_fire = imem_req_valid && imem_req_ready;
  assign rsp_take = imem_rsp_valid && (outstanding != '0);
  assign out_next = outstanding + CW'(req_fire)
                  - CW'(rsp_take);

  // in-flight requests are contiguous and end just below pc
  assign rsp_pc = pc - ADDR_WIDTH'(outstanding)
                     * ADDR_WIDTH'(PC_STEP);

  assign rsp_entry = '{pc: rsp_pc, inst: imem_rsp_data};

  assign flush = redirect_valid && (state != IDLE);
  assign push  = in_fetch && rsp_take && !redirect_valid;
  assign pop   = inst_valid && inst_ready && !redirect_valid;

  assign inst_valid = in_fetch && !buf_empty;
  assign inst       = head.inst;
  assign inst_pc    = head.pc;

  fetch_fifo #(
    .DEPTH (BUF_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .push      (push),
    .pop       (pop),
    .push_data (rsp_entry),
    .head      (head),
    .empty     (buf_empty),
    .count     (occupancy)
  );

  // control FSM with pc and in-flight request count
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      outstanding <= '0;
    end else begin
      outstanding <= out_next;
      unique case (state)
        IDLE: begin
          state <= FETCH;
        end
        FETCH: begin
          if (redirect_valid) begin
            pc    <= target;
            state <= (out_next != '0) ? FLUSH : FETCH;
          end else if (req_fire) begin
            pc <= pc + ADDR_WIDTH'(PC_STEP);
          end
        end
        FLUSH: begin
          if (redirect_valid) begin
            pc <= target;
          end else if (out_next == '0) begin
            state <= FETCH;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef FETCH_STATS_EN
  // count consumed instructions and redirects
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_fetched <= '0;
      stat_flushes <= '0;
    end else begin
      if (pop) begin
        stat_fetched <= stat_fetched + 1'b1;
      end
      if (flush) begin
        stat_flushes <= stat_flushes + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: memory responder plus fetch-order model.
// Stats ports are checked when FETCH_STATS_EN is defined.
module tb_fetch_unit;

  localparam logic [63:0] RST_PC = 64'h0;
  localparam int          DEPTH  = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [63:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [63:0] inst_pc;
`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched;
  logic [31:0] stat_flushes;
`endif

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC  (RST_PC),
    .BUF_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc)
`ifdef FETCH_STATS_EN
    ,
    .stat_fetched   (stat_fetched),
    .stat_flushes   (stat_flushes)
`endif
  );

  typedef struct {
    logic [63:0] addr;
    int          gen;
  } req_t;

  req_t        q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cfg_req_ready = 1;
  int          cfg_inst_ready = 1;
  bit          cfg_reset = 1'b1;
  int          credits = -1;
  bit          rsp_rand = 1'b0;
  bit          redir_pend = 1'b0;
  logic [63:0] redir_tgt = '0;
  logic [63:0] exp_req_pc = RST_PC;
  logic [63:0] exp_inst_pc = RST_PC;
  int          live = 0;
  int          gen = 0;
  int          n_req = 0;
  int          n_pop = 0;
  int          n_redir = 0;
  bit          prev_reset = 1'b0;
  bit          primed = 1'b0;
  bit          fired;
  logic [63:0] fired_addr;
  bit          popped;
  logic [63:0] popped_pc;

  function automatic logic [31:0] memfn(logic [63:0] a);
    return a[31:0] ^ {a[15:0], a[31:16]} ^ a[63:32]
         ^ 32'h5A5A_1234;
  endfunction

  // one clock cycle: drive inputs, then update the model
  task automatic step();
    req_t e;
    @(negedge clk);
    reset = cfg_reset;
    imem_req_ready = (cfg_req_ready == 2) ?
      1'($urandom_range(1, 0)) : 1'(cfg_req_ready);
    inst_ready = (cfg_inst_ready == 2) ?
      1'($urandom_range(1, 0)) : 1'(cfg_inst_ready);
    redirect_valid = redir_pend;
    redirect_pc = redir_tgt;
    redir_pend = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = '0;
    if (!cfg_reset && q.size() > 0 && credits != 0 &&
        (!rsp_rand || $urandom_range(1, 0) == 1)) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data = memfn(q[0].addr);
      if (credits > 0) credits--;
    end
    #1;
    fired = 1'b0;
    popped = 1'b0;
`ifdef FETCH_STATS_EN
    if (primed) begin
      n_checks++;
      if (stat_fetched !== 32'(n_pop)) begin
        n_fail++;
        $display("FAIL stat_fetched: got %0d want %0d",
                 stat_fetched, n_pop);
      end
      n_checks++;
      if (stat_flushes !== 32'(n_redir)) begin
        n_fail++;
        $display("FAIL stat_flushes: got %0d want %0d",
                 stat_flushes, n_redir);
      end
    end
`endif
    if (cfg_reset) begin
      if (prev_reset) begin
        n_checks++;
        if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL in_reset: req_valid=%b inst_valid=%b want 0 0",
                   imem_req_valid, inst_valid);
        end
      end
      exp_req_pc = RST_PC;
      exp_inst_pc = RST_PC;
      live = 0;
      gen++;
      n_pop = 0;
      n_redir = 0;
      primed = 1'b1;
    end else begin
      if (imem_rsp_valid) begin
        e = q.pop_front();
        if (e.gen == gen) live--;
      end
      if (imem_req_valid && imem_req_ready) begin
        n_checks++;
        if (imem_addr !== exp_req_pc) begin
          n_fail++;
          $display("FAIL req_addr: got %h want %h",
                   imem_addr, exp_req_pc);
        end
        q.push_back('{imem_addr, gen});
        live++;
        n_req++;
        fired = 1'b1;
        fired_addr = imem_addr;
        exp_req_pc = exp_req_pc + 64'd4;
      end
      if (redirect_valid) begin
        exp_req_pc = redirect_pc & ~64'h3;
        exp_inst_pc = redirect_pc & ~64'h3;
        n_redir++;
      end else if (inst_valid && inst_ready) begin
        n_checks++;
        if (inst_pc !== exp_inst_pc) begin
          n_fail++;
          $display("FAIL inst_pc: got %h want %h",
                   inst_pc, exp_inst_pc);
        end
        n_checks++;
        if (inst !== memfn(exp_inst_pc)) begin
          n_fail++;
          $display("FAIL inst_data: got %h want %h",
                   inst, memfn(exp_inst_pc));
        end
        popped = 1'b1;
        popped_pc = inst_pc;
        exp_inst_pc = exp_inst_pc + 64'd4;
        n_pop++;
      end
      n_checks++;
      if (live > DEPTH) begin
        n_fail++;
        $display("FAIL in_flight: got %0d want <= %0d",
                 live, DEPTH);
      end
    end
    prev_reset = cfg_reset;
  endtask

  task automatic do_reset();
    q.delete();
    cfg_reset = 1'b1;
    step();
    step();
    cfg_reset = 1'b0;
  endtask

  task automatic wait_fire(output bit ok,
                           output logic [63:0] a);
    ok = 1'b0;
    a = '0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (fired) begin
        ok = 1'b1;
        a = fired_addr;
        return;
      end
    end
  endtask

  task automatic wait_pop(output bit ok,
                          output logic [63:0] a);
    ok = 1'b0;
    a = '0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (popped) begin
        ok = 1'b1;
        a = popped_pc;
        return;
      end
    end
  endtask

  task automatic stream_cfg();
    cfg_req_ready = 1;
    cfg_inst_ready = 1;
    credits = -1;
    rsp_rand = 1'b0;
  endtask

  task automatic test_reset();
    stream_cfg();
    cfg_reset = 1'b1;
    step();
    step();
    n_checks++;
    if (imem_req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_req_valid: got %b want 0",
               imem_req_valid);
    end
    n_checks++;
    if (inst_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_inst_valid: got %b want 0", inst_valid);
    end
    n_checks++;
    if (inst !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_inst: got %h want 0", inst);
    end
    n_checks++;
    if (inst_pc !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_inst_pc: got %h want 0", inst_pc);
    end
    cfg_reset = 1'b0;
    step();
    n_checks++;
    if (imem_req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_req_valid: got %b want 0",
               imem_req_valid);
    end
    step();
    n_checks++;
    if (imem_req_valid !== 1'b1 || imem_addr !== RST_PC) begin
      n_fail++;
      $display("FAIL first_req: got v=%b a=%h want v=1 a=%h",
               imem_req_valid, imem_addr, RST_PC);
    end
  endtask

  task automatic test_stream();
    int cnt;
    stream_cfg();
    do_reset();
    step();
    step();
    n_checks++;
    if (fired !== 1'b1 || inst_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stream_t0: got fire=%b iv=%b want 1 0",
               fired, inst_valid);
    end
    step();
    n_checks++;
    if (inst_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rsp_to_inst_path: got iv=%b want 0",
               inst_valid);
    end
    step();
    n_checks++;
    if (inst_valid !== 1'b1 || inst_pc !== RST_PC) begin
      n_fail++;
      $display("FAIL stream_first: got iv=%b pc=%h want 1 %h",
               inst_valid, inst_pc, RST_PC);
    end
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (popped) cnt++;
    end
    n_checks++;
    if (cnt != 20) begin
      n_fail++;
      $display("FAIL stream_rate: got %0d want 20", cnt);
    end
  endtask

  task automatic test_backpressure();
    int base;
    stream_cfg();
    cfg_inst_ready = 0;
    do_reset();
    base = n_req;
    for (int i = 0; i < 12; i++) step();
    n_checks++;
    if (n_req - base != DEPTH) begin
      n_fail++;
      $display("FAIL bp_requests: got %0d want %0d",
               n_req - base, DEPTH);
    end
    n_checks++;
    if (imem_req_valid !== 1'b0 || inst_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_stall: got rv=%b iv=%b want 0 1",
               imem_req_valid, inst_valid);
    end
    cfg_inst_ready = 1;
    step();
    cfg_inst_ready = 0;
    for (int i = 0; i < 4; i++) step();
    n_checks++;
    if (n_req - base != DEPTH + 1) begin
      n_fail++;
      $display("FAIL bp_after_pop: got %0d want %0d",
               n_req - base, DEPTH + 1);
    end
  endtask

  task automatic test_redirect();
    bit ok;
    logic [63:0] a;
    stream_cfg();
    credits = 0;
    do_reset();
    step();
    step();
    step();
    cfg_req_ready = 0;
    redir_pend = 1'b1;
    redir_tgt = 64'h100;
    step();
    cfg_req_ready = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (imem_req_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL flush_req_valid: got %b want 0",
                 imem_req_valid);
      end
    end
    credits = -1;
    wait_fire(ok, a);
    n_checks++;
    if (!ok || a !== 64'h100) begin
      n_fail++;
      $display("FAIL redir_addr: got %h seen=%0d want 100", a, ok);
    end
    wait_pop(ok, a);
    n_checks++;
    if (!ok || a !== 64'h100) begin
      n_fail++;
      $display("FAIL redir_inst_pc: got %h seen=%0d want 100", a, ok);
    end
    redir_pend = 1'b1;
    redir_tgt = 64'h203;
    step();
    wait_fire(ok, a);
    n_checks++;
    if (!ok || a !== 64'h200) begin
      n_fail++;
      $display("FAIL align_addr: got %h seen=%0d want 200", a, ok);
    end
  endtask

  task automatic test_redirect_rsp_pop();
    bit ok;
    logic [63:0] a;
    stream_cfg();
    cfg_inst_ready = 0;
    credits = 0;
    do_reset();
    for (int i = 0; i < 7; i++) step();
    credits = 1;
    step();
    step();
    n_checks++;
    if (inst_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rrp_setup: got iv=%b want 1", inst_valid);
    end
    credits = 1;
    redir_pend = 1'b1;
    redir_tgt = 64'h300;
    cfg_inst_ready = 1;
    step();
    credits = 0;
    step();
    n_checks++;
    if (inst_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rrp_empty: got iv=%b rv=%b want 0 0",
               inst_valid, imem_req_valid);
    end
    credits = -1;
    wait_pop(ok, a);
    n_checks++;
    if (!ok || a !== 64'h300) begin
      n_fail++;
      $display("FAIL rrp_first_pc: got %h seen=%0d want 300", a, ok);
    end
  endtask

  task automatic test_reset_midflight();
    bit ok;
    logic [63:0] a;
    stream_cfg();
    cfg_req_ready = 0;
    credits = 0;
    do_reset();
    step();
    step();
    redir_pend = 1'b1;
    redir_tgt = 64'h480;
    step();
    cfg_req_ready = 1;
    step();
    cfg_req_ready = 0;
    step();
    cfg_reset = 1'b1;
    step();
    step();
    cfg_reset = 1'b0;
    step();
    credits = 1;
    step();
    credits = -1;
    cfg_req_ready = 1;
    wait_pop(ok, a);
    n_checks++;
    if (!ok || a !== RST_PC) begin
      n_fail++;
      $display("FAIL midflight_pc: got %h seen=%0d want %h",
               a, ok, RST_PC);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    logic [63:0] a;
    logic [63:0] exp_w [4];
    exp_w[0] = 64'hFFFF_FFFF_FFFF_FFF8;
    exp_w[1] = 64'hFFFF_FFFF_FFFF_FFFC;
    exp_w[2] = 64'h0;
    exp_w[3] = 64'h4;
    stream_cfg();
    do_reset();
    for (int i = 0; i < 4; i++) step();
    redir_pend = 1'b1;
    redir_tgt = 64'hFFFF_FFFF_FFFF_FFFA;
    step();
    for (int i = 0; i < 4; i++) begin
      wait_pop(ok, a);
      n_checks++;
      if (!ok || a !== exp_w[i]) begin
        n_fail++;
        $display("FAIL wrap_pc%0d: got %h seen=%0d want %h",
                 i, a, ok, exp_w[i]);
      end
    end
  endtask

  task automatic test_random();
    stream_cfg();
    do_reset();
    step();
    cfg_req_ready = 2;
    cfg_inst_ready = 2;
    rsp_rand = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(39, 0) == 0) begin
        redir_pend = 1'b1;
        if ($urandom_range(3, 0) == 0)
          redir_tgt = {32'hFFFF_FFFF, $urandom};
        else
          redir_tgt = {$urandom, $urandom};
      end
      step();
    end
    n_checks++;
    if (n_pop < 300) begin
      n_fail++;
      $display("FAIL random_progress: got %0d pops want >= 300",
               n_pop);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_rsp_pop();
    test_reset_midflight();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0, first fetch address after reset.
REQ-002 SHALL have parameter BUF_DEPTH, default 2, instruction buffer entries and max in-flight requests (legal 2..8).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port imem_req_valid  output  1  fetch request valid.
REQ-006 SHALL have port imem_req_ready  input  1  memory accepts request.
REQ-007 SHALL have port imem_addr  output  64  fetch byte address, bits [1:0] always zero.
REQ-008 SHALL have port imem_rsp_valid  input  1  instruction word returned, in request order, never before the cycle after acceptance.
REQ-009 SHALL have port imem_rsp_data  input  32  returned instruction word.
REQ-010 SHALL have port redirect_valid  input  1  taken branch (CBZ or B) resolved downstream.
REQ-011 SHALL have port redirect_pc  input  64  branch target.
REQ-012 SHALL have port inst_valid  output  1  instruction available to decode/control.
REQ-013 SHALL have port inst_ready  input  1  decode consumes instruction.
REQ-014 SHALL have port inst  output  32  instruction word to decode/control unit.
REQ-015 SHALL have port inst_pc  output  64  address of inst.

Function
REQ-016 SHALL implement FSM states IDLE, FETCH, FLUSH; IDLE -> FETCH unconditionally one cycle after reset deasserts.
REQ-017 SHALL assert imem_req_valid only in FETCH and only when outstanding + buffer occupancy < BUF_DEPTH.
REQ-018 SHALL count request handshake (imem_req_valid & imem_req_ready) as one outstanding, and increment pc by 4 (modulo 2^64, wrap silent).
REQ-019 SHALL decrement outstanding on imem_rsp_valid; in FETCH write {pc of request, imem_rsp_data} to buffer tail.
REQ-020 SHALL present buffer head on inst/inst_pc with inst_valid = buffer non-empty; pop on inst_valid & inst_ready.
REQ-021 SHALL have no combinational path from imem_rsp_* to inst_*; response in cycle N visible on inst_valid at N+1 at earliest.
REQ-022 SHALL allow simultaneous push and pop when buffer full, occupancy unchanged.
REQ-023 On redirect_valid in FETCH: flush buffer, pc <= {redirect_pc[63:2],2'b00}, next state FLUSH if outstanding after this cycle's updates (including a request accepted same cycle) > 0, else FETCH.
REQ-024 SHALL give redirect priority over same-cycle pc increment, buffer push and pop; response arriving in redirect cycle discarded.
REQ-025 In FLUSH: imem_req_valid = 0, responses discarded, inst_valid = 0; -> FETCH when outstanding reaches 0.
REQ-026 redirect_valid in FLUSH SHALL update pc and remain in FLUSH.
REQ-027 imem_rsp_valid with outstanding == 0 SHALL be ignored.

Reset
REQ-028 On reset: state IDLE, pc = RESET_PC, outstanding 0, buffer empty, imem_req_valid 0, inst_valid 0, inst 0, inst_pc 0.
REQ-029 Reset mid-flight SHALL abandon outstanding requests; later responses ignored via REQ-027.

Configuration
REQ-030 With FETCH_STATS_EN defined: add outputs stat_fetched (32, increments per pop) and stat_flushes (32, increments per redirect), both reset to 0 and wrap; without it: ports and counters absent, behaviour otherwise identical.

Structure
REQ-031 Shared package SHALL hold fetch FSM state enum, INST_WIDTH=32, ADDR_WIDTH=64, PC_STEP=4.
REQ-032 Buffer SHALL be sub-module fetch_fifo (parameterised depth, entry {pc,inst}, flush input).

Verification
REQ-033 Reset, imem_req_ready=1, 1-cycle response latency, inst_ready=1 -> addresses 0,4,8,... ; inst_pc matches, one inst per cycle steady state.
REQ-034 inst_ready=0 -> exactly BUF_DEPTH requests issued, then imem_req_valid=0 until a pop.
REQ-035 Redirect to 0x100 with 2 outstanding -> FLUSH, both responses dropped, next imem_addr 0x100, first inst_pc 0x100.
REQ-036 Redirect to 0x203 -> imem_addr 0x200.
REQ-037 Redirect same cycle as response and pop -> response discarded, buffer empty next cycle.
REQ-038 Reset asserted with 1 outstanding, response returns after reset -> ignored, first inst_pc = RESET_PC.
